dma_channel: RTL and testbench

Single-channel DMA engine acting as a bus initiator on the system memory bus (addr/data/width/read/write/ok). It is the master-side counterpart of the memory responder. When started, it copies a programmed number of halfword or word units from a source address to a destination address, one read followed by one write per unit. It arbitrates with the CPU through a req/gnt pair, and it raises a one-cycle done pulse for the interrupt controller.

---
 rtl/dma_channel.sv | 164 ++++++++++++++++
 tb/tb_dma_channel.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel.sv
// Single-channel DMA initiator: copies halfword/word units from a source to a
// destination address, one bus read then one bus write per unit, with req/gnt arbitration.
module dma_channel #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_src,
    input  logic [31:0]        cfg_dst,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               cfg_word,
    input  logic [1:0]         cfg_src_ctl,
    input  logic [1:0]         cfg_dst_ctl,
    output logic               bus_req,
    input  logic               bus_gnt,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic [31:0]        bus_rdata,
    output logic [1:0]         bus_width,
    output logic               bus_read,
    output logic               bus_write,
    input  logic               bus_ok,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [COUNT_W:0] LAST_UNIT  = {{COUNT_W{1'b0}}, 1'b1};
    localparam logic [COUNT_W:0] FULL_COUNT = {1'b1, {COUNT_W{1'b0}}};

    state_t             state_r;
    logic [31:0]        src_r;
    logic [31:0]        dst_r;
    logic [COUNT_W:0]   remain_r;
    logic               word_r;
    logic [1:0]         src_ctl_r;
    logic [1:0]         dst_ctl_r;
    logic [31:0]        src_step_s;
    logic [31:0]        dst_step_s;

    function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic word);
        return addr & (word ? 32'hFFFF_FFFC : 32'hFFFF_FFFE);
    endfunction

    // Control 2'b11 deliberately behaves like increment; arithmetic wraps modulo 2^32.
    function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [1:0] ctl,
                                              input logic word);
        logic [31:0] step;
        step = word ? 32'd4 : 32'd2;
        case (ctl)
            2'b01:   return addr - step;
            2'b10:   return addr;
            default: return addr + step;
        endcase
    endfunction

    assign src_step_s = step_addr(src_r, src_ctl_r, word_r);
    assign dst_step_s = step_addr(dst_r, dst_ctl_r, word_r);

    // Transfer FSM with all bus/status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            src_r     <= 32'h0000_0000;
            dst_r     <= 32'h0000_0000;
            remain_r  <= {(COUNT_W+1){1'b0}};
            word_r    <= 1'b1;
            src_ctl_r <= 2'b00;
            dst_ctl_r <= 2'b00;
            bus_req   <= 1'b0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_wdata <= 32'h0000_0000;
            bus_width <= 2'h2;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_REQ;
                        src_r     <= align_addr(cfg_src, cfg_word);
                        dst_r     <= align_addr(cfg_dst, cfg_word);
                        remain_r  <= (cfg_count == {COUNT_W{1'b0}}) ? FULL_COUNT
                                                                    : {1'b0, cfg_count};
                        word_r    <= cfg_word;
                        src_ctl_r <= cfg_src_ctl;
                        dst_ctl_r <= cfg_dst_ctl;
                        bus_width <= cfg_word ? 2'h2 : 2'h1;
                        bus_req   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state_r  <= ST_READ;
                        bus_read <= 1'b1;
                        bus_addr <= src_r;
                    end
                end
                ST_READ: begin
                    if (bus_ok) begin
                        state_r   <= ST_WRITE;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b1;
                        bus_addr  <= dst_r;
                        bus_wdata <= word_r ? bus_rdata : {bus_rdata[15:0], bus_rdata[15:0]};
                    end
                end
                ST_WRITE: begin
                    // Grant is only re-checked here, so a read/write pair is never split.
                    if (bus_ok) begin
                        bus_write <= 1'b0;
                        src_r     <= src_step_s;
                        dst_r     <= dst_step_s;
                        remain_r  <= remain_r - LAST_UNIT;
                        if (remain_r == LAST_UNIT) begin
                            state_r <= ST_DONE;
                            bus_req <= 1'b0;
                            done    <= 1'b1;
                        end else if (bus_gnt) begin
                            state_r  <= ST_READ;
                            bus_read <= 1'b1;
                            bus_addr <= src_step_s;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req   <= 1'b0;
                    bus_read  <= 1'b0;
                    bus_write <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel.sv
// Bench for dma_channel: directed vector table, hand-written corner sequences and
// randomized transfers checked against a unit-list reference model.
module tb_dma_channel;
    localparam int CW = 4;
    localparam int NSNAP = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   cfg_src = 32'h0;
    logic [31:0]   cfg_dst = 32'h0;
    logic [CW-1:0] cfg_count = '0;
    logic          cfg_word = 1'b0;
    logic [1:0]    cfg_src_ctl = 2'b00;
    logic [1:0]    cfg_dst_ctl = 2'b00;
    logic          bus_gnt = 1'b0;
    logic          bus_ok = 1'b0;
    logic [31:0]   bus_rdata;
    logic          bus_req, bus_read, bus_write, busy, done;
    logic [31:0]   bus_addr, bus_wdata;
    logic [1:0]    bus_width;

    dma_channel #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count), .cfg_word(cfg_word),
        .cfg_src_ctl(cfg_src_ctl), .cfg_dst_ctl(cfg_dst_ctl),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_width(bus_width), .bus_read(bus_read),
        .bus_write(bus_write), .bus_ok(bus_ok), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    assign bus_rdata = mem_val(bus_addr);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] rd_addr_q[$];
    logic [1:0]  rd_w_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [1:0]  wr_w_q[$];
    logic        snap_req[NSNAP], snap_rd[NSNAP], snap_wr[NSNAP], snap_busy[NSNAP], snap_done[NSNAP];
    logic [31:0] snap_addr[NSNAP], snap_wdata[NSNAP];
    logic [1:0]  snap_width[NSNAP];
    int          done_cnt, done_cyc;
    bit          viol, timeout;

    // One transfer; cycle 1 is the first cycle after the edge that samples start.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [CW-1:0] cnt,
                            input logic word, input logic [1:0] sctl, input logic [1:0] dctl,
                            input int gnt_lo_a, input int gnt_lo_b, input int ok_lo_a, input int ok_lo_b,
                            input int abort_cyc, input int rst_cyc, input bit rnd);
        logic prev_rd, prev_wr, prev_ok, prev_kill;
        logic [31:0] prev_addr, prev_wdata;
        int cyc, idle_seen;
        rd_addr_q.delete(); rd_w_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_w_q.delete();
        for (int i = 0; i < NSNAP; i++) begin
            snap_req[i] = 1'b0; snap_rd[i] = 1'b0; snap_wr[i] = 1'b0; snap_busy[i] = 1'b0;
            snap_done[i] = 1'b0; snap_addr[i] = 32'h0; snap_wdata[i] = 32'h0; snap_width[i] = 2'h0;
        end
        done_cnt = 0; done_cyc = -1; viol = 1'b0; timeout = 1'b0;
        @(negedge clk);
        cfg_src = src; cfg_dst = dst; cfg_count = cnt; cfg_word = word;
        cfg_src_ctl = sctl; cfg_dst_ctl = dctl;
        start = 1'b1; abort = (abort_cyc == 0); bus_gnt = 1'b1; bus_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; idle_seen = 0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_ok = 1'b1; prev_kill = 1'b0;
        prev_addr = 32'h0; prev_wdata = 32'h0;
        while (idle_seen < 3 && cyc < 600) begin
            abort = (cyc == abort_cyc);
            rst_n = (cyc != rst_cyc);
            if (rnd) begin
                bus_gnt = ($urandom_range(0, 3) != 0);
                bus_ok  = ($urandom_range(0, 3) != 0);
            end else begin
                bus_gnt = !(cyc >= gnt_lo_a && cyc <= gnt_lo_b);
                bus_ok  = !(cyc >= ok_lo_a && cyc <= ok_lo_b);
            end
            if (cyc < NSNAP) begin
                snap_req[cyc] = bus_req; snap_rd[cyc] = bus_read; snap_wr[cyc] = bus_write;
                snap_busy[cyc] = busy; snap_done[cyc] = done; snap_addr[cyc] = bus_addr;
                snap_wdata[cyc] = bus_wdata; snap_width[cyc] = bus_width;
            end
            if (bus_read && bus_write) viol = 1'b1;
            if ((bus_read || bus_write) && !bus_req) viol = 1'b1;
            if (prev_rd && !prev_ok && !prev_kill && (!bus_read || bus_addr !== prev_addr)) viol = 1'b1;
            if (prev_wr && !prev_ok && !prev_kill &&
                (!bus_write || bus_addr !== prev_addr || bus_wdata !== prev_wdata)) viol = 1'b1;
            if (bus_read && bus_ok) begin rd_addr_q.push_back(bus_addr); rd_w_q.push_back(bus_width); end
            if (bus_write && bus_ok) begin
                wr_addr_q.push_back(bus_addr); wr_data_q.push_back(bus_wdata); wr_w_q.push_back(bus_width);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy) idle_seen++;
            prev_rd = bus_read; prev_wr = bus_write; prev_ok = bus_ok;
            prev_kill = abort || !rst_n; prev_addr = bus_addr; prev_wdata = bus_wdata;
            @(negedge clk);
            cyc++;
        end
        if (idle_seen < 3) timeout = 1'b1;
        abort = 1'b0; rst_n = 1'b1; bus_gnt = 1'b1; bus_ok = 1'b1;
    endtask

    // Reference: list of units derived from the configuration with plain address arithmetic.
    task automatic check_model(input string tag, input logic [31:0] src, input logic [31:0] dst,
                               input logic [CW-1:0] cnt, input logic word,
                               input logic [1:0] sctl, input logic [1:0] dctl);
        int n, m;
        logic [31:0] s, d, step, data;
        n = (cnt == '0) ? 16 : int'(cnt);
        step = word ? 32'd4 : 32'd2;
        s = word ? {src[31:2], 2'b00} : {src[31:1], 1'b0};
        d = word ? {dst[31:2], 2'b00} : {dst[31:1], 1'b0};
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " protocol"}, 32'(viol), 32'd0);
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " reads"}, 32'(rd_addr_q.size()), 32'(n));
        check({tag, " writes"}, 32'(wr_addr_q.size()), 32'(n));
        m = n;
        if (rd_addr_q.size() < m) m = rd_addr_q.size();
        if (wr_addr_q.size() < m) m = wr_addr_q.size();
        for (int k = 0; k < m; k++) begin
            data = mem_val(s);
            check($sformatf("%s rd_addr[%0d]", tag, k), rd_addr_q[k], s);
            check($sformatf("%s wr_addr[%0d]", tag, k), wr_addr_q[k], d);
            check($sformatf("%s wdata[%0d]", tag, k), wr_data_q[k], word ? data : {data[15:0], data[15:0]});
            check($sformatf("%s rd_width[%0d]", tag, k), 32'(rd_w_q[k]), word ? 32'd2 : 32'd1);
            check($sformatf("%s wr_width[%0d]", tag, k), 32'(wr_w_q[k]), word ? 32'd2 : 32'd1);
            if (sctl == 2'b01) s = s - step; else if (sctl != 2'b10) s = s + step;
            if (dctl == 2'b01) d = d - step; else if (dctl != 2'b10) d = d + step;
        end
    endtask

    typedef struct {
        logic [31:0]   src;
        logic [31:0]   dst;
        logic [CW-1:0] cnt;
        logic          word;
        logic [1:0]    sctl;
        logic [1:0]    dctl;
        logic [31:0]   first_rd;
        logic [31:0]   last_wr;
        int            done_at;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0800_0000, 32'h0800_0100, 4'd4, 1'b1, 2'b00, 2'b00, 32'h0800_0000, 32'h0800_010C, 10};
        vecs[1] = '{32'h0000_0002, 32'h0600_0000, 4'd3, 1'b0, 2'b00, 2'b10, 32'h0000_0002, 32'h0600_0000, 8};
        vecs[2] = '{32'h0800_0013, 32'h0800_0200, 4'd2, 1'b1, 2'b01, 2'b00, 32'h0800_0010, 32'h0800_0204, 6};
        vecs[3] = '{32'h0800_1000, 32'h0800_2000, 4'd0, 1'b1, 2'b11, 2'b10, 32'h0800_1000, 32'h0800_2000, 34};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFE, 4'd2, 1'b0, 2'b01, 2'b00, 32'h0000_0000, 32'h0000_0000, 6};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0010, 4'd3, 1'b1, 2'b00, 2'b01, 32'hFFFF_FFFC, 32'h0000_0008, 8};

        repeat (3) @(negedge clk);
        check("reset ctl", 32'({bus_req, bus_read, bus_write, busy, done}), 32'd0);
        check("reset addr", bus_addr, 32'h0);
        check("reset wdata", bus_wdata, 32'h0);
        check("reset width", 32'(bus_width), 32'd2);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].word, vecs[v].sctl, vecs[v].dctl,
                     -1, -1, -1, -1, -1, -1, 1'b0);
            check_model($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].word,
                        vecs[v].sctl, vecs[v].dctl);
            check($sformatf("vec%0d cyc1 req", v), 32'({snap_req[1], snap_rd[1], snap_busy[1]}), 32'd5);
            check($sformatf("vec%0d first rd", v), rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hDEAD_BEEF,
                  vecs[v].first_rd);
            check($sformatf("vec%0d last wr", v),
                  wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : 32'hDEAD_BEEF, vecs[v].last_wr);
            check($sformatf("vec%0d done cyc", v), 32'(done_cyc), 32'(vecs[v].done_at));
            check($sformatf("vec%0d busy after", v), 32'(snap_busy[vecs[v].done_at + 1]), 32'd0);
        end

        // Grant withdrawn during unit 1 write, back three cycles later.
        run_xfer(32'h0800_0000, 32'h0800_0100, 4'd4, 1'b1, 2'b00, 2'b00, 5, 7, -1, -1, -1, -1, 1'b0);
        check_model("gntloss", 32'h0800_0000, 32'h0800_0100, 4'd4, 1'b1, 2'b00, 2'b00);
        check("gntloss u1 write", 32'(snap_wr[5]), 32'd1);
        check("gntloss u1 waddr", snap_addr[5], 32'h0800_0104);
        for (int c = 6; c <= 8; c++)
            check($sformatf("gntloss req cyc%0d", c), 32'({snap_req[c], snap_rd[c], snap_wr[c]}), 32'd4);
        check("gntloss resume rd", 32'(snap_rd[9]), 32'd1);
        check("gntloss resume addr", snap_addr[9], 32'h0800_0008);
        check("gntloss done cyc", 32'(done_cyc), 32'd13);

        // Read stalled two cycles by the responder.
        run_xfer(32'h0800_0000, 32'h0800_0100, 4'd2, 1'b1, 2'b00, 2'b00, -1, -1, 2, 3, -1, -1, 1'b0);
        check_model("okstall", 32'h0800_0000, 32'h0800_0100, 4'd2, 1'b1, 2'b00, 2'b00);
        for (int c = 2; c <= 4; c++) begin
            check($sformatf("okstall rd cyc%0d", c), 32'({snap_rd[c], snap_wr[c]}), 32'd2);
            check($sformatf("okstall addr cyc%0d", c), snap_addr[c], 32'h0800_0000);
        end
        check("okstall done cyc", 32'(done_cyc), 32'd8);

        // Abort during unit 1 read.
        run_xfer(32'h0800_0000, 32'h0800_0100, 4'd4, 1'b1, 2'b00, 2'b00, -1, -1, -1, -1, 4, -1, 1'b0);
        check("abort idle next", 32'({snap_req[5], snap_rd[5], snap_wr[5], snap_busy[5]}), 32'd0);
        check("abort no done", 32'(done_cnt), 32'd0);
        check("abort writes", 32'(wr_addr_q.size()), 32'd1);
        check("abort timeout", 32'(timeout), 32'd0);

        // Reset during a halfword transfer.
        run_xfer(32'h0000_1000, 32'h0000_2000, 4'd4, 1'b0, 2'b00, 2'b00, -1, -1, -1, -1, -1, 4, 1'b0);
        check("rst ctl", 32'({snap_req[5], snap_rd[5], snap_wr[5], snap_busy[5], snap_done[5]}), 32'd0);
        check("rst addr", snap_addr[5], 32'h0);
        check("rst wdata", snap_wdata[5], 32'h0);
        check("rst width", 32'(snap_width[5]), 32'd2);
        check("rst no done", 32'(done_cnt), 32'd0);

        // Abort together with start in idle: start wins.
        run_xfer(32'h0000_0040, 32'h0000_0080, 4'd1, 1'b1, 2'b00, 2'b00, -1, -1, -1, -1, 0, -1, 1'b0);
        check_model("startabort", 32'h0000_0040, 32'h0000_0080, 4'd1, 1'b1, 2'b00, 2'b00);
        check("startabort cyc1", 32'({snap_req[1], snap_busy[1]}), 32'd3);
        check("startabort done cyc", 32'(done_cyc), 32'd4);

        for (int r = 0; r < 40; r++) begin
            logic [31:0] s, d;
            logic [CW-1:0] n;
            logic w;
            logic [1:0] sc, dc;
            s = $urandom; d = $urandom; n = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1));
            sc = 2'($urandom_range(0, 3)); dc = 2'($urandom_range(0, 3));
            run_xfer(s, d, n, w, sc, dc, -1, -1, -1, -1, -1, -1, 1'b1);
            check_model($sformatf("rnd%0d", r), s, d, n, w, sc, dc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
